// File: rtl/alu_wb_handshake_if.sv
// ALU-result / register-file writeback bundle.
// slave = writeback stage view, master = ALU + register file view.
interface alu_wb_handshake_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic [4:0]  in_rd;
  logic        in_we;
  logic        in_set_flags;
  logic        in_zero;
  logic        in_neg;
  logic        in_carry;
  logic        in_ovf;
  logic        wb_req;
  logic        wb_ack;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  flags;
  logic        wb_busy;
  logic        wb_err;

  modport slave (
    input  in_valid, in_result, in_rd, in_we,
    input  in_set_flags, in_zero, in_neg,
    input  in_carry, in_ovf, wb_ack,
    output in_ready, wb_req, wb_addr, wb_data,
    output flags, wb_busy, wb_err
  );

  modport master (
    output in_valid, in_result, in_rd, in_we,
    output in_set_flags, in_zero, in_neg,
    output in_carry, in_ovf, wb_ack,
    input  in_ready, wb_req, wb_addr, wb_data,
    input  flags, wb_busy, wb_err
  );
endinterface

// File: rtl/alu_wb_handshake.sv
// ALU writeback stage: result FIFO, flags register and
// 4-phase req/ack delivery to the register file.
module alu_wb_handshake #(
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input logic              clk,
  input logic              rst_n,
  alu_wb_handshake_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL
  } state_t;

  wb_ent_t          r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  state_t           r_state;
  logic             r_req;
  logic [4:0]       r_addr;
  logic [31:0]      r_data;
  logic [3:0]       r_flags;
  logic             r_err;
  logic [7:0]       r_tmo;

  logic    w_full;
  logic    w_empty;
  logic    w_acc;
  logic    w_push;
  logic    w_pop;
  logic    w_ack;
  logic    w_tmo_hit;
  logic    w_tmo_sat;
  wb_ent_t w_head;

  assign w_full    = (r_cnt == CW'(DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_acc     = bus.in_valid & ~w_full;
  assign w_push    = w_acc & bus.in_we
                   & (bus.in_rd != 5'd0);
  assign w_ack     = r_sync[SYNC_STAGES-1];
  assign w_pop     = (r_state == S_REQ) & w_ack;
  assign w_head    = r_mem[r_rptr];
  assign w_tmo_hit = (r_tmo == 8'(TIMEOUT - 1));
  assign w_tmo_sat = (r_tmo == 8'(TIMEOUT));

  assign bus.in_ready = ~w_full;
  assign bus.wb_req   = r_req;
  assign bus.wb_addr  = r_addr;
  assign bus.wb_data  = r_data;
  assign bus.flags    = r_flags;
  assign bus.wb_err   = r_err;
  assign bus.wb_busy  = ~w_empty
                      | (r_state != S_IDLE);

  // Ack may be asynchronous; nothing reads it before the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0],
                 bus.wb_ack};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= '{rd:   bus.in_rd,
                           data: bus.in_result};
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Flags track every accepted op, regardless of writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_acc & bus.in_set_flags) begin
      r_flags <= {bus.in_zero, bus.in_neg,
                  bus.in_carry, bus.in_ovf};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_addr  <= w_head.rd;
            r_data  <= w_head.data;
            r_req   <= 1'b1;
            r_tmo   <= '0;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (w_ack) begin
            r_req   <= 1'b0;
            r_tmo   <= '0;
            r_state <= S_REL;
          end else begin
            if (!w_tmo_sat) r_tmo <= r_tmo + 8'd1;
            if (w_tmo_hit)  r_err <= 1'b1;
          end
        end
        S_REL: begin
          if (!w_ack) begin
            r_tmo   <= '0;
            r_state <= S_IDLE;
          end else begin
            if (!w_tmo_sat) r_tmo <= r_tmo + 8'd1;
            if (w_tmo_hit)  r_err <= 1'b1;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wb_handshake.sv
// Bench for alu_wb_handshake: directed cases plus a
// randomized run against a queue-based reference model.
module tb_alu_wb_handshake;

  localparam int DEPTH = 2;
  localparam int SYNC  = 2;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_wb_handshake_if bus ();

  alu_wb_handshake #(
    .DEPTH(DEPTH),
    .SYNC_STAGES(SYNC),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [36:0] exp_q [$];
  logic [3:0]  exp_flags;
  int          pushed;
  int          popped;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    bus.in_valid     = 1'b0;
    bus.in_we        = 1'b0;
    bus.in_rd        = '0;
    bus.in_result    = '0;
    bus.in_set_flags = 1'b0;
    bus.in_zero      = 1'b0;
    bus.in_neg       = 1'b0;
    bus.in_carry     = 1'b0;
    bus.in_ovf       = 1'b0;
  endtask

  task automatic send(input logic [4:0] rd,
                      input logic [31:0] d,
                      input logic we,
                      input logic sf,
                      input logic [3:0] f);
    bus.in_valid     = 1'b1;
    bus.in_rd        = rd;
    bus.in_result    = d;
    bus.in_we        = we;
    bus.in_set_flags = sf;
    {bus.in_zero, bus.in_neg,
     bus.in_carry, bus.in_ovf} = f;
  endtask

  task automatic wait_req(input logic lvl,
                          input string tag);
    int n = 0;
    while (bus.wb_req !== lvl && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.wb_req, lvl);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.wb_busy !== 1'b0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, bus.wb_busy, 0);
  endtask

  task automatic serve(input logic [4:0] rd,
                       input logic [31:0] d,
                       input string tag);
    wait_req(1'b1, {tag, "_req"});
    chk({tag, "_addr"}, bus.wb_addr, rd);
    chk({tag, "_data"}, bus.wb_data, d);
    bus.wb_ack = 1'b1;
    wait_req(1'b0, {tag, "_rel"});
    bus.wb_ack = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [36:0] e;
    logic [4:0]  r_rd;
    logic [31:0] r_d;
    logic        r_we;
    logic        r_sf;
    logic [3:0]  r_f;
    logic        prev_req;
    int          dly;
    int          cyc;
    bit          drive;

    rst_n      = 1'b0;
    bus.wb_ack = 1'b0;
    idle_in();
    #12;
    chk("rst_req",   bus.wb_req,  0);
    chk("rst_addr",  bus.wb_addr, 0);
    chk("rst_data",  bus.wb_data, 0);
    chk("rst_flags", bus.flags,   0);
    chk("rst_err",   bus.wb_err,  0);
    chk("rst_busy",  bus.wb_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_ready", bus.in_ready, 1);

    // single write with prompt ack
    send(5'd3, 32'hDEADBEEF, 1'b1, 1'b0, 4'h0);
    @(negedge clk);
    idle_in();
    chk("t1_req_t", bus.wb_req, 0);
    @(negedge clk);
    chk("t1_req_t1", bus.wb_req, 1);
    chk("t1_addr", bus.wb_addr, 3);
    chk("t1_data", bus.wb_data, 32'hDEADBEEF);
    bus.wb_ack = 1'b1;
    for (int k = 0; k < SYNC; k++) begin
      @(negedge clk);
      chk("t1_req_hold", bus.wb_req, 1);
    end
    @(negedge clk);
    chk("t1_req_fall", bus.wb_req, 0);
    bus.wb_ack = 1'b0;
    for (int k = 0; k < SYNC; k++) begin
      @(negedge clk);
      chk("t1_busy_rel", bus.wb_busy, 1);
    end
    @(negedge clk);
    chk("t1_busy_done", bus.wb_busy, 0);

    // back-pressure with ack stalled
    chk("t2_ready0", bus.in_ready, 1);
    send(5'd1, 32'h111, 1'b1, 1'b0, 4'h0);
    @(negedge clk);
    chk("t2_ready1", bus.in_ready, 1);
    send(5'd2, 32'h222, 1'b1, 1'b0, 4'h0);
    @(negedge clk);
    chk("t2_full", bus.in_ready, 0);
    send(5'd3, 32'h333, 1'b1, 1'b0, 4'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_stall", bus.in_ready, 0);
    end
    chk("t2_head_req", bus.wb_req, 1);
    chk("t2_head_addr", bus.wb_addr, 1);
    chk("t2_head_data", bus.wb_data, 32'h111);
    bus.wb_ack = 1'b1;
    begin
      int n = 0;
      while (bus.in_ready !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("t2_ready_pop", bus.in_ready, 1);
    chk("t2_pop_req", bus.wb_req, 0);
    @(negedge clk);
    idle_in();
    bus.wb_ack = 1'b0;
    chk("t2_refull", bus.in_ready, 0);
    serve(5'd2, 32'h222, "t2_w2");
    serve(5'd3, 32'h333, "t2_w3");
    wait_idle("t2_idle");

    // flag-only op
    send(5'd4, 32'h0, 1'b0, 1'b1, 4'b1010);
    @(negedge clk);
    idle_in();
    chk("t3_flags", bus.flags, 4'b1010);
    chk("t3_req", bus.wb_req, 0);
    chk("t3_busy", bus.wb_busy, 0);
    chk("t3_ready", bus.in_ready, 1);

    // rd=0 write is dropped
    send(5'd0, 32'd5, 1'b1, 1'b0, 4'h0);
    @(negedge clk);
    idle_in();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t4_req", bus.wb_req, 0);
      chk("t4_busy", bus.wb_busy, 0);
    end
    chk("t4_flags", bus.flags, 4'b1010);

    // randomized traffic against the queue model
    exp_flags = 4'b1010;
    pushed    = 0;
    popped    = 0;
    prev_req  = 1'b0;
    dly       = int'($urandom_range(0, 3));
    drive     = 1'b1;
    cyc       = 0;
    while (cyc < 1500) begin
      if (cyc == 400) drive = 1'b0;
      if (bus.wb_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_addr", bus.wb_addr, e[36:32]);
          chk("rnd_data", bus.wb_data, e[31:0]);
        end
      end
      if (!bus.wb_req && prev_req) popped++;
      prev_req = bus.wb_req;
      chk("rnd_ready", bus.in_ready,
          (pushed - popped) < DEPTH);
      chk("rnd_flags", bus.flags, exp_flags);
      if (bus.wb_req !== bus.wb_ack) begin
        if (dly == 0) begin
          bus.wb_ack = bus.wb_req;
          dly = int'($urandom_range(0, 3));
        end else begin
          dly--;
        end
      end
      if (drive && $urandom_range(0, 9) < 6) begin
        r_rd = 5'($urandom_range(0, 31));
        r_d  = $urandom;
        r_we = ($urandom_range(0, 3) != 0);
        r_sf = 1'($urandom_range(0, 1));
        r_f  = 4'($urandom_range(0, 15));
        send(r_rd, r_d, r_we, r_sf, r_f);
        if ((pushed - popped) < DEPTH) begin
          if (r_sf) exp_flags = r_f;
          if (r_we && r_rd != 5'd0) begin
            exp_q.push_back({r_rd, r_d});
            pushed++;
          end
        end
      end else begin
        idle_in();
      end
      if (!drive && exp_q.size() == 0 &&
          bus.wb_busy === 1'b0 &&
          bus.wb_ack === 1'b0)
        break;
      @(negedge clk);
      cyc++;
    end
    idle_in();
    chk("rnd_drain_busy", bus.wb_busy, 0);
    chk("rnd_drain_q", exp_q.size(), 0);
    chk("rnd_err", bus.wb_err, 0);

    // timeout while ack is held low
    send(5'd7, 32'h7777, 1'b1, 1'b0, 4'h0);
    @(negedge clk);
    idle_in();
    wait_req(1'b1, "t5_req");
    for (int k = 1; k < TMO; k++) @(negedge clk);
    chk("t5_err_early", bus.wb_err, 0);
    @(negedge clk);
    chk("t5_err", bus.wb_err, 1);
    chk("t5_req_held", bus.wb_req, 1);
    chk("t5_addr", bus.wb_addr, 7);
    bus.wb_ack = 1'b1;
    wait_req(1'b0, "t5_rel");
    bus.wb_ack = 1'b0;
    wait_idle("t5_idle");
    chk("t5_err_sticky", bus.wb_err, 1);

    // async reset in the middle of REQ
    send(5'd9, 32'h99, 1'b1, 1'b1, 4'b0110);
    @(negedge clk);
    idle_in();
    wait_req(1'b1, "t6_req");
    chk("t6_flags", bus.flags, 4'b0110);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_req", bus.wb_req, 0);
    chk("t6_flags0", bus.flags, 0);
    chk("t6_addr", bus.wb_addr, 0);
    chk("t6_data", bus.wb_data, 0);
    chk("t6_err", bus.wb_err, 0);
    chk("t6_busy", bus.wb_busy, 0);
    #1 rst_n = 1'b1;
    #1;
    chk("t6_ready", bus.in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_no_req", bus.wb_req, 0);
    end

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/alu_wb_handshake.md
Name: alu_wb_handshake

Overview:
- Writeback stage directly downstream of the ALU.
- Captures each ALU result together with its destination register and status flags, and buffers it in a small FIFO.
- Delivers each buffered result to the register file over a 4-phase req/ack handshake.
- Also maintains the architectural flags register (Z, N, C, V), which is updated by CMP and other flag-setting ops.

Parameters:
- DEPTH, 2: result FIFO entries (power of 2, >=2)
- SYNC_STAGES, 2: flip-flop stages on the incoming wb_ack (>=2)
- TIMEOUT, 255: max cycles in REQ or RELEASE before wb_err is raised (8-bit counter)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept (!full)
- in_result  in  32  ALU Result
- in_rd  in  5  destination register index
- in_we  in  1  result is to be written
- in_set_flags  in  1  update flags from this op
- in_zero, in_neg, in_carry, in_ovf  in  1 each  ALU status outputs
- wb_req  out  1  4-phase request to register file
- wb_ack  in  1  4-phase acknowledge (may be asynchronous to clk)
- wb_addr  out  5  register index
- wb_data  out  32  write data
- flags  out  4  {Z,N,C,V} architectural flags
- wb_busy  out  1  FIFO non-empty or FSM not IDLE
- wb_err  out  1  sticky handshake timeout

Behaviour:
- Reset (async, rst_n=0): all outputs clear immediately.
  - wb_req=0, wb_addr=0, wb_data=0, flags=0, wb_err=0, wb_busy=0.
  - FIFO is emptied, FSM goes to IDLE, sync chain clears.
  - in_ready=1 once rst_n=1.
  - Reset mid-handshake drops wb_req with no completion; the register file must tolerate this.
- Accept: in_valid & in_ready at a rising edge.
  - in_ready = !full, from the registered count only.
  - A pop in the same cycle does not admit a push when full.
- Flags: updated on the accept edge whenever in_set_flags=1, independent of in_we and of FIFO/writeback progress.
  - flags <= {in_zero, in_neg, in_carry, in_ovf}.
- FIFO push rule:
  - Entry {rd, result} is pushed only if in_we=1 and in_rd!=0.
  - Accepts with in_we=0 or rd=0 consume no FIFO slot; they only update flags if in_set_flags=1.
- FSM states:
  - IDLE: if FIFO non-empty, latch head into wb_addr/wb_data, set wb_req=1, go to REQ.
    - wb_req rises the edge after the head becomes valid.
    - Push into an empty FIFO at edge t -> wb_req=1 after edge t+1.
  - REQ: wb_addr/wb_data held stable.
    - When synchronized ack=1: wb_req<=0, pop the FIFO, go to RELEASE.
  - RELEASE: wait for synchronized ack=0, then go to IDLE.
    - A new request never starts while ack is still seen high.
- Throughput: 1 write per (SYNC_STAGES*2 + 3) cycles minimum with zero-delay ack.
- wb_ack passes through SYNC_STAGES flops before use; this is the only ack path.
- Timeout:
  - Counter resets on every state entry and increments each cycle in REQ or RELEASE.
  - On reaching TIMEOUT, wb_err<=1 (sticky until reset).
  - The handshake keeps waiting; there is no abort.
- Ordering: writes retire strictly in accept order.
- FIFO pointers wrap modulo DEPTH; count is width clog2(DEPTH)+1.
- wb_busy = (count!=0) | (state!=IDLE).

Test Plan:
- Reset then single write, ack responds 1 cycle after wb_req and drops 1 cycle after req falls:
  - Accept rd=3, result=0xDEADBEEF.
  - Expect wb_req=1 at edge t+1 with wb_addr=3, wb_data=0xDEADBEEF.
  - Expect wb_req=0 SYNC_STAGES+1 edges after ack rises.
  - Expect wb_busy=0 after the ack falls and is synchronized.
- Back-pressure:
  - Stall ack low; push 3 writes back-to-back with DEPTH=2.
  - Expect in_ready=0 after 2 accepted; third accepted only after first pop.
  - Expect order rd=1,2,3 retained.
- Flag-only op:
  - CMP with in_we=0, in_set_flags=1, Z=1, N=0, C=1, V=0.
  - Expect flags=4'b1010 the next cycle, no wb_req, FIFO count unchanged.
- rd=0 drop: in_we=1, rd=0, result=5 -> no wb_req ever; wb_busy stays 0.
- Timeout: hold wb_ack=0 with TIMEOUT=8 -> wb_err=1 after 8 cycles in REQ, wb_req still 1; later ack completes normally with wb_err still 1.
- Async reset mid-REQ: drop rst_n between edges -> wb_req=0, flags=0, in_ready=1 (after release) without waiting for clk.
